// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter between ALU and load writeback into the register file; 1-cycle latency to write port.
// Readies are combinational and drop to 0 under hold or reset; losing requester must hold its request.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              hold,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              last_grant,
  output logic [7:0]        conflict_count
);

  logic open;
  logic conflict;

  assign open     = !rst && !hold;
  assign conflict = open && alu_valid && mem_valid;

  // last_grant=1 means MEM won the previous conflict, so ALU is next in line.
  assign alu_ready = open && alu_valid && (!mem_valid || last_grant);
  assign mem_ready = open && mem_valid && (!alu_valid || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg      <= '0;
      write_data     <= '0;
      reg_write      <= 1'b0;
      last_grant     <= 1'b1;
      conflict_count <= 8'd0;
    end else begin
      if (alu_ready) begin
        write_reg  <= alu_reg;
        write_data <= alu_data;
        reg_write  <= |alu_reg;
      end else if (mem_ready) begin
        write_reg  <= mem_reg;
        write_data <= mem_data;
        reg_write  <= |mem_reg;
      end else begin
        reg_write  <= 1'b0;
      end

      if (conflict) begin
        last_grant <= mem_ready;
        if (conflict_count != 8'hFF) begin
          conflict_count <= conflict_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector bench for reg_wb_arbiter: table of cycles plus a long conflict-saturation run.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        hold;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        last_grant;
  logic [7:0]  conflict_count;

  int errors = 0;
  int checks = 0;

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .hold(hold),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .last_grant(last_grant), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, hold;
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        mv; logic [4:0] mr; logic [31:0] md;
    logic        e_ar, e_mr, e_rw;
    logic [4:0]  e_wr; logic [31:0] e_wd;
    logic        e_lg; logic [7:0] e_cc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic h,
                              logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic e_ar, logic e_mr, logic e_rw,
                              logic [4:0] e_wr, logic [31:0] e_wd,
                              logic e_lg, logic [7:0] e_cc);
    vec_t v;
    v.rst = r; v.hold = h;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_rw = e_rw;
    v.e_wr = e_wr; v.e_wd = e_wd; v.e_lg = e_lg; v.e_cc = e_cc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; hold = v.hold;
    alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
    mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
  endtask

  initial begin
    logic exp_alu;
    vec_t v;

    rst = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;

    //                 rst hold av ar  ad            mv mr  md            ear emr erw wr  wd            lg cc
    vecs.push_back(mk(1, 0,   1, 3,  32'h1,        1, 5,  32'h2,        0,  0,  0,  0,  32'h0,        1, 0)); // reset with both valid
    vecs.push_back(mk(0, 0,   1, 8,  32'h1234,     0, 0,  32'h0,        1,  0,  1,  8,  32'h1234,     1, 0)); // single ALU write
    vecs.push_back(mk(0, 0,   0, 0,  32'h0,        0, 0,  32'h0,        0,  0,  0,  8,  32'h1234,     1, 0)); // idle holds data
    vecs.push_back(mk(0, 0,   1, 3,  32'hAAAA,     1, 5,  32'hBBBB,     1,  0,  1,  3,  32'hAAAA,     0, 1)); // conflict: ALU first
    vecs.push_back(mk(0, 0,   1, 3,  32'hAAAA,     1, 5,  32'hBBBB,     0,  1,  1,  5,  32'hBBBB,     1, 2)); // conflict: MEM next
    vecs.push_back(mk(0, 0,   0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 0,  1,  0,  0,  32'hFFFFFFFF, 1, 2)); // $zero load
    vecs.push_back(mk(0, 0,   0, 0,  32'h0,        1, 7,  32'h77,       0,  1,  1,  7,  32'h77,       1, 2)); // single MEM
    vecs.push_back(mk(0, 1,   1, 9,  32'h99,       1, 10, 32'hA0,       0,  0,  0,  7,  32'h77,       1, 2)); // hold x3
    vecs.push_back(mk(0, 1,   1, 9,  32'h99,       1, 10, 32'hA0,       0,  0,  0,  7,  32'h77,       1, 2));
    vecs.push_back(mk(0, 1,   1, 9,  32'h99,       1, 10, 32'hA0,       0,  0,  0,  7,  32'h77,       1, 2));
    vecs.push_back(mk(0, 0,   1, 9,  32'h99,       1, 10, 32'hA0,       1,  0,  1,  9,  32'h99,       0, 3)); // hold released
    vecs.push_back(mk(0, 0,   1, 9,  32'h99,       1, 10, 32'hA0,       0,  1,  1,  10, 32'hA0,       1, 4));
    vecs.push_back(mk(0, 0,   1, 4,  32'h44,       0, 0,  32'h0,        1,  0,  1,  4,  32'h44,       1, 4)); // single ALU keeps last_grant
    vecs.push_back(mk(0, 0,   1, 9,  32'h99,       1, 10, 32'hA0,       1,  0,  1,  9,  32'h99,       0, 5));
    vecs.push_back(mk(1, 0,   1, 9,  32'h99,       1, 10, 32'hA0,       0,  0,  0,  0,  32'h0,        1, 0)); // reset mid-conflict
    vecs.push_back(mk(0, 0,   1, 9,  32'h99,       1, 10, 32'hA0,       1,  0,  1,  9,  32'h99,       0, 1)); // ALU wins after reset
    vecs.push_back(mk(0, 0,   1, 0,  32'h55,       0, 0,  32'h0,        1,  0,  0,  0,  32'h55,       0, 1)); // ALU write to $zero

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ar));
      chk("mem_ready", i, 32'(mem_ready), 32'(vecs[i].e_mr));
      @(posedge clk);
      #1;
      chk("reg_write", i, 32'(reg_write), 32'(vecs[i].e_rw));
      chk("write_reg", i, 32'(write_reg), 32'(vecs[i].e_wr));
      chk("write_data", i, write_data, vecs[i].e_wd);
      chk("last_grant", i, 32'(last_grant), 32'(vecs[i].e_lg));
      chk("conflict_count", i, 32'(conflict_count), 32'(vecs[i].e_cc));
    end

    // 300 back-to-back conflicts: last table row left last_grant=0, so MEM wins first.
    v = mk(0, 0, 1, 11, 32'h1111, 1, 12, 32'h2222, 0, 0, 0, 0, 0, 0, 0);
    exp_alu = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive(v);
      #1;
      chk("sat_alu_ready", c, 32'(alu_ready), 32'(exp_alu));
      chk("sat_mem_ready", c, 32'(mem_ready), 32'(!exp_alu));
      @(posedge clk);
      #1;
      chk("sat_write_reg", c, 32'(write_reg), exp_alu ? 32'd11 : 32'd12);
      if (c == 253) chk("sat_count_254", c, 32'(conflict_count), 32'd255);
      exp_alu = !exp_alu;
    end
    chk("sat_count_final", 300, 32'(conflict_count), 32'd255);

    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_reg_write", 301, 32'(reg_write), 32'd0);
    chk("idle_count", 301, 32'(conflict_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
